// File: rtl/mfp_eic_controller.sv
// External interrupt controller for a MIPS core in EIC mode: sense, pend, prioritise, present.
// Optional macro MFP_EIC_SYNC_EN inserts a 2-flop synchronizer on irq_in.
module mfp_eic_controller #(
    parameter int unsigned EIC_CHANNELS = 32
) (
    input  logic                    SI_ClkIn,
    input  logic                    SI_Reset,
    input  logic [EIC_CHANNELS-1:0] irq_in,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [EIC_CHANNELS-1:0] cfg_wdata,
    output logic [EIC_CHANNELS-1:0] cfg_rdata,
    input  logic                    EIC_IAck,
    output logic [5:0]              EIC_RIPL,
    output logic [5:0]              EIC_Vector,
    output logic [3:0]              EIC_EISS,
    output logic                    eic_busy
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPresent = 2'd1;
    localparam logic [1:0] StRetire  = 2'd2;

    logic [EIC_CHANNELS-1:0] mask_q, mask_d, sense_q, sense_d, pend_q, pend_d, prev_q;
    logic [EIC_CHANNELS-1:0] irq_s, elig, rise, force_set, w1c, ack_vec;
    logic [1:0]              state_q, state_d;
    logic [5:0]              vector_q, vector_d, ripl_q, ripl_d, win;
    logic                    busy_q, busy_d, any_elig, ack_hit;
    logic                    wr_mask, wr_sense, wr_pend, wr_force;

`ifdef MFP_EIC_SYNC_EN
    logic [EIC_CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign wr_mask  = cfg_we && (cfg_addr == 2'd0);
    assign wr_sense = cfg_we && (cfg_addr == 2'd1);
    assign wr_pend  = cfg_we && (cfg_addr == 2'd2);
    assign wr_force = cfg_we && (cfg_addr == 2'd3);

    assign elig     = pend_q & mask_q;
    assign any_elig = |elig;
    assign ack_hit  = (state_q == StPresent) && EIC_IAck;

    // Highest eligible index wins.
    always_comb begin
        win = '0;
        for (int i = 0; i < int'(EIC_CHANNELS); i++) begin
            if (elig[i]) win = 6'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(EIC_CHANNELS); i++) begin
            ack_vec[i] = ack_hit && (vector_q == 6'(i));
        end
    end

    // Sets (force, edge) dominate clears so a coinciding event is never lost;
    // level channels simply follow the line.
    assign rise      = irq_s & ~prev_q;
    assign force_set = wr_force ? cfg_wdata : '0;
    assign w1c       = wr_pend ? cfg_wdata : '0;
    assign pend_d    = force_set
                     | (sense_q & (rise | (pend_q & ~(w1c | ack_vec))))
                     | (~sense_q & irq_s);
    assign mask_d    = wr_mask ? cfg_wdata : mask_q;
    assign sense_d   = wr_sense ? cfg_wdata : sense_q;

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ripl_d   = ripl_q;
        busy_d   = busy_q;
        case (state_q)
            StIdle: begin
                if (any_elig) begin
                    state_d  = StPresent;
                    vector_d = win;
                    ripl_d   = win + 6'd1;
                    busy_d   = 1'b1;
                end
            end
            StPresent: begin
                if (EIC_IAck) begin
                    state_d = StRetire;
                    ripl_d  = '0;
                end else if (!any_elig) begin
                    state_d = StIdle;
                    ripl_d  = '0;
                    busy_d  = 1'b0;
                end else if (win != vector_q) begin
                    vector_d = win;
                    ripl_d   = win + 6'd1;
                end
            end
            StRetire: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                ripl_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            mask_q   <= '0;
            sense_q  <= '0;
            pend_q   <= '0;
            prev_q   <= '0;
            state_q  <= StIdle;
            vector_q <= '0;
            ripl_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            sense_q  <= sense_d;
            pend_q   <= pend_d;
            prev_q   <= irq_s;
            state_q  <= state_d;
            vector_q <= vector_d;
            ripl_q   <= ripl_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = mask_q;
            2'd1:    cfg_rdata = sense_q;
            2'd2:    cfg_rdata = pend_q;
            default: cfg_rdata = '0;
        endcase
    end

    assign EIC_RIPL   = ripl_q;
    assign EIC_Vector = vector_q;
    assign EIC_EISS   = 4'd0;
    assign eic_busy   = busy_q;

endmodule

// File: tb/tb_mfp_eic_controller.sv
// Bench for mfp_eic_controller: priority table, directed corner sequences, random vs reference model.
module tb_mfp_eic_controller;

    localparam int CH = 32;
`ifdef MFP_EIC_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic          clk = 1'b0;
    logic          SI_Reset = 1'b1;
    logic [CH-1:0] irq_in = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [CH-1:0] cfg_wdata = '0;
    logic [CH-1:0] cfg_rdata;
    logic          EIC_IAck = 1'b0;
    logic [5:0]    EIC_RIPL, EIC_Vector;
    logic [3:0]    EIC_EISS;
    logic          eic_busy;

    int total = 0;
    int bad = 0;

    mfp_eic_controller #(.EIC_CHANNELS(CH)) dut (
        .SI_ClkIn  (clk),
        .SI_Reset  (SI_Reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .EIC_IAck  (EIC_IAck),
        .EIC_RIPL  (EIC_RIPL),
        .EIC_Vector(EIC_Vector),
        .EIC_EISS  (EIC_EISS),
        .eic_busy  (eic_busy)
    );

    always #5 clk = ~clk;

    // Reference model: registers as bit vectors, the request as "offered channel" plus cool-down.
    bit [CH-1:0] m_mask, m_sense, m_pend, m_prev;
    bit [CH-1:0] m_pipe[$];
    int          m_vec;
    bit          m_offer, m_cool;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit [CH-1:0] irq_eff, elig, npend;
        int top;
        bit took;
        if (SI_Reset) begin
            m_mask = '0; m_sense = '0; m_pend = '0; m_prev = '0;
            m_vec = 0; m_offer = 0; m_cool = 0;
            m_pipe = {};
            repeat (S) m_pipe.push_back('0);
            return;
        end
        if (S == 0) irq_eff = irq_in;
        else begin
            irq_eff = m_pipe.pop_front();
            m_pipe.push_back(irq_in);
        end
        elig = m_pend & m_mask;
        top = -1;
        for (int i = CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                top = i;
                break;
            end
        end
        took = m_offer && EIC_IAck;
        for (int i = 0; i < CH; i++) begin
            if (cfg_we && cfg_addr == 2'd3 && cfg_wdata[i]) npend[i] = 1'b1;
            else if (!m_sense[i]) npend[i] = irq_eff[i];
            else if (irq_eff[i] && !m_prev[i]) npend[i] = 1'b1;
            else if ((cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) || (took && i == m_vec))
                npend[i] = 1'b0;
            else npend[i] = m_pend[i];
        end
        if (m_cool) m_cool = 0;
        else if (m_offer) begin
            if (took) begin
                m_offer = 0;
                m_cool = 1;
            end else if (top < 0) m_offer = 0;
            else m_vec = top;
        end else if (top >= 0) begin
            m_offer = 1;
            m_vec = top;
        end
        m_prev = irq_eff;
        m_pend = npend;
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
        if (cfg_we && cfg_addr == 2'd1) m_sense = cfg_wdata;
    endtask

    task automatic cmp_all();
        bit [CH-1:0] exp_rd;
        case (cfg_addr)
            2'd0:    exp_rd = m_mask;
            2'd1:    exp_rd = m_sense;
            2'd2:    exp_rd = m_pend;
            default: exp_rd = '0;
        endcase
        chk("model ripl", EIC_RIPL, m_offer ? m_vec + 1 : 0);
        chk("model vector", EIC_Vector, m_vec);
        chk("model busy", eic_busy, m_offer || m_cool);
        chk("eiss", EIC_EISS, 0);
        chk("model rdata", cfg_rdata, exp_rd);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic wr(input logic [1:0] a, input logic [CH-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        cyc();
        cfg_we = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [CH-1:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic do_reset();
        SI_Reset = 1'b1;
        irq_in = '0;
        EIC_IAck = 1'b0;
        cyc();
        SI_Reset = 1'b0;
    endtask

    typedef struct {
        logic [CH-1:0] mask;
        logic [CH-1:0] frc;
        logic [5:0]    ripl;
        logic [5:0]    vec;
    } vec_t;

    vec_t tv[7];

    initial begin
        logic [CH-1:0] d;
        tv[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 6'd1, 6'd0};
        tv[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 6'd32, 6'd31};
        tv[2] = '{32'h0000_00A0, 32'h0000_00A0, 6'd8, 6'd7};
        tv[3] = '{32'h0000_0020, 32'h0000_00A0, 6'd6, 6'd5};
        tv[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 6'd0, 6'd0};
        tv[5] = '{32'h0001_0000, 32'h0001_8000, 6'd17, 6'd16};
        tv[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 6'd31, 6'd30};

        do_reset();
        chk("reset ripl", EIC_RIPL, 0);
        chk("reset vector", EIC_Vector, 0);
        chk("reset busy", eic_busy, 0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("reset rdata", d, 0);
        end

        // Priority table: all edge-sensed, pending forced, check the winner.
        for (int k = 0; k < 7; k++) begin
            do_reset();
            wr(2'd1, '1);
            wr(2'd0, tv[k].mask);
            wr(2'd3, tv[k].frc);
            cyc();
            chk("table ripl", EIC_RIPL, tv[k].ripl);
            chk("table vector", EIC_Vector, tv[k].vec);
            rd(2'd2, d);
            chk("table pending", d, tv[k].frc);
            rd(2'd3, d);
            chk("table force reads 0", d, 0);
        end

        // Single edge channel, then acknowledge.
        do_reset();
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'h80);
        irq_in[7] = 1'b1;
        cyc();
        irq_in = '0;
        repeat (S) cyc();
        rd(2'd2, d);
        chk("edge pend7", d[7], 1);
        chk("edge not yet", EIC_RIPL, 0);
        cyc();
        chk("edge ripl", EIC_RIPL, 8);
        chk("edge vector", EIC_Vector, 7);
        chk("edge busy", eic_busy, 1);
        EIC_IAck = 1'b1;
        cyc();
        EIC_IAck = 1'b0;
        chk("ack ripl", EIC_RIPL, 0);
        chk("ack busy retire", eic_busy, 1);
        rd(2'd2, d);
        chk("ack pend7", d[7], 0);
        cyc();
        chk("ack busy idle", eic_busy, 0);

        // Preemption by a higher channel, then return to the lower one.
        do_reset();
        wr(2'd0, 32'hE0);
        wr(2'd1, 32'hE0);
        irq_in[5] = 1'b1;
        cyc();
        irq_in = '0;
        repeat (S + 1) cyc();
        chk("prio ripl5", EIC_RIPL, 6);
        chk("prio vec5", EIC_Vector, 5);
        irq_in[6] = 1'b1;
        cyc();
        irq_in = '0;
        repeat (S + 1) cyc();
        chk("prio ripl6", EIC_RIPL, 7);
        chk("prio vec6", EIC_Vector, 6);
        EIC_IAck = 1'b1;
        cyc();
        EIC_IAck = 1'b0;
        chk("prio ack ripl", EIC_RIPL, 0);
        cyc();
        cyc();
        chk("prio re-present ripl", EIC_RIPL, 6);
        chk("prio re-present vec", EIC_Vector, 5);

        // Level channel keeps re-presenting until the source drops.
        do_reset();
        wr(2'd0, 32'h40);
        irq_in[6] = 1'b1;
        cyc();
        repeat (S) cyc();
        cyc();
        chk("level ripl", EIC_RIPL, 7);
        EIC_IAck = 1'b1;
        cyc();
        EIC_IAck = 1'b0;
        chk("level retire ripl", EIC_RIPL, 0);
        cyc();
        cyc();
        chk("level again ripl", EIC_RIPL, 7);
        irq_in[6] = 1'b0;
        cyc();
        repeat (S) cyc();
        cyc();
        chk("level drop ripl", EIC_RIPL, 0);
        chk("level drop busy", eic_busy, 0);

        // Mask withdraw leaves pending intact.
        do_reset();
        wr(2'd1, 32'h08);
        wr(2'd0, 32'h08);
        irq_in[3] = 1'b1;
        cyc();
        irq_in = '0;
        repeat (S + 1) cyc();
        chk("mask present", EIC_RIPL, 4);
        wr(2'd0, 32'h0);
        cyc();
        chk("mask withdrawn ripl", EIC_RIPL, 0);
        chk("mask withdrawn busy", eic_busy, 0);
        rd(2'd2, d);
        chk("mask pend3 kept", d[3], 1);
        wr(2'd0, 32'h08);
        cyc();
        chk("mask re-present", EIC_RIPL, 4);

        // Force with level sense, and W1C colliding with a rising edge.
        do_reset();
        wr(2'd0, 32'h02);
        wr(2'd3, 32'h02);
        cyc();
        chk("force ripl", EIC_RIPL, 2);
        chk("force vector", EIC_Vector, 1);
        do_reset();
        wr(2'd1, 32'h10);
        wr(2'd3, 32'h10);
        irq_in[4] = 1'b1;
        repeat (S) cyc();
        wr(2'd2, 32'h10);
        rd(2'd2, d);
        chk("w1c vs edge", d[4], 1);
        wr(2'd2, 32'h10);
        rd(2'd2, d);
        chk("w1c clears", d[4], 0);
        irq_in = '0;

        // Reset while presenting.
        do_reset();
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h01);
        wr(2'd3, 32'h01);
        cyc();
        chk("pre-reset ripl", EIC_RIPL, 1);
        do_reset();
        chk("midreset ripl", EIC_RIPL, 0);
        chk("midreset vector", EIC_Vector, 0);
        chk("midreset busy", eic_busy, 0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("midreset rdata", d, 0);
        end

        // Random traffic against the model.
        do_reset();
        wr(2'd0, '1);
        for (int n = 0; n < 3000; n++) begin
            irq_in = irq_in ^ ($urandom() & $urandom() & $urandom());
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_wdata = (cfg_addr == 2'd0) ? ($urandom() | $urandom()) : $urandom();
            EIC_IAck = ($urandom_range(0, 2) == 0);
            SI_Reset = ($urandom_range(0, 299) == 0);
            cyc();
        end
        SI_Reset = 1'b0;
        cfg_we = 1'b0;
        EIC_IAck = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
